core_rrv_vga_fill_ctrl: RTL and testbench

- Hardware fill/copy engine and port-A arbiter for the VGA frame memory (640x480, 1 bpp, 9600 x 32-bit words).
- Sits between the core's Q503/Q504 VGA memory access path and the memory's port A. The VGA scan-out port B is not touched.
- Clears or patterns regions (fill) and scrolls text or graphics (ascending word copy) without core load/store loops.
- The core always has priority; the engine uses idle port-A cycles only.

---
 rtl/core_rrv_vga_fill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_core_rrv_vga_fill_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_rrv_vga_fill_ctrl.sv
// Fill/copy engine and port-A arbiter for the 640x480 1 bpp VGA frame memory.
// The core always owns port A when it accesses; the engine runs only in idle cycles.
module core_rrv_vga_fill_ctrl #(
  parameter int MEM_WORDS = 9600,
  parameter int AW        = 14
) (
  input  logic          Clk_50,
  input  logic          Reset,
  input  logic          CoreWrEnQ503,
  input  logic          CoreRdEnQ503,
  input  logic [31:0]   CoreAddrQ503H,
  input  logic [31:0]   CoreDataQ503H,
  input  logic [3:0]    CoreByteEnQ503H,
  output logic [31:0]   CoreRspDataQ504H,
  input  logic          CmdValid,
  output logic          CmdReady,
  input  logic          CmdOp,
  input  logic [AW-1:0] CmdDstWord,
  input  logic [AW-1:0] CmdSrcWord,
  input  logic [AW-1:0] CmdLenWords,
  input  logic [31:0]   CmdPattern,
  output logic [AW-1:0] MemAddrWord,
  output logic [31:0]   MemData,
  output logic [3:0]    MemByteEn,
  output logic          MemWrEn,
  output logic          MemRdEn,
  input  logic [31:0]   MemRspData,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [2:0] {
    IDLE, FILL, COPY_RD, COPY_CAP, COPY_WR, DONE
  } state_t;

  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_WORDS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] dst, dst_nxt;
  logic [AW-1:0] src, src_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [31:0]   pattern, pattern_nxt;
  logic [31:0]   hold_data, hold_nxt;
  logic          op, op_nxt;

  logic          core_access;
  logic          grant;
  logic          eng_wr;
  logic          eng_rd;
  logic [AW-1:0] eng_addr;
  logic [31:0]   eng_data;
  logic          unused_addr_bits;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == LAST_WORD) ? '0 : a + 1'b1;
  endfunction

  assign core_access      = CoreWrEnQ503 | CoreRdEnQ503;
  assign grant            = !core_access;
  assign unused_addr_bits = ^{CoreAddrQ503H[31:AW+2], CoreAddrQ503H[1:0]};

  assign eng_wr   = (state == FILL) || (state == COPY_WR);
  assign eng_rd   = (state == COPY_RD);
  assign eng_addr = (state == COPY_RD) ? src : dst;
  assign eng_data = op ? hold_data : pattern;

  assign CmdReady         = (state == IDLE);
  assign Busy             = (state == FILL) || (state == COPY_RD) ||
                            (state == COPY_CAP) || (state == COPY_WR);
  assign Done             = (state == DONE);
  assign CoreRspDataQ504H = MemRspData;

  // Port-A mux: the core wins outright, the engine fills the gaps.
  always_comb begin
    MemAddrWord = eng_addr;
    MemData     = eng_data;
    MemByteEn   = 4'hF;
    MemWrEn     = eng_wr;
    MemRdEn     = eng_rd;
    if (core_access) begin
      MemAddrWord = CoreAddrQ503H[AW+1:2];
      MemData     = CoreDataQ503H;
      MemByteEn   = CoreByteEnQ503H;
      MemWrEn     = CoreWrEnQ503;
      MemRdEn     = CoreRdEnQ503;
    end
  end

  always_comb begin
    // NOTE: every next-state variable is defaulted first so no path can infer a latch.
    state_nxt   = state;
    dst_nxt     = dst;
    src_nxt     = src;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    hold_nxt    = hold_data;
    op_nxt      = op;
    unique case (state)
      IDLE: begin
        if (CmdValid) begin
          dst_nxt     = CmdDstWord;
          src_nxt     = CmdSrcWord;
          cnt_nxt     = CmdLenWords;
          pattern_nxt = CmdPattern;
          op_nxt      = CmdOp;
          if (CmdLenWords == '0) state_nxt = DONE;
          else if (CmdOp)        state_nxt = COPY_RD;
          else                   state_nxt = FILL;
        end
      end
      FILL: begin
        if (grant) begin
          dst_nxt = wrap_inc(dst);
          cnt_nxt = cnt - 1'b1;
          if (cnt == AW'(1)) state_nxt = DONE;
        end
      end
      COPY_RD: begin
        if (grant) begin
          src_nxt   = wrap_inc(src);
          state_nxt = COPY_CAP;
        end
      end
      COPY_CAP: begin
        // Read data from the previous cycle's grant is on MemRspData now.
        hold_nxt  = MemRspData;
        state_nxt = COPY_WR;
      end
      COPY_WR: begin
        if (grant) begin
          dst_nxt   = wrap_inc(dst);
          cnt_nxt   = cnt - 1'b1;
          state_nxt = (cnt == AW'(1)) ? DONE : COPY_RD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge Clk_50 or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      dst       <= '0;
      src       <= '0;
      cnt       <= '0;
      pattern   <= '0;
      hold_data <= '0;
      op        <= 1'b0;
    end else begin
      state     <= state_nxt;
      dst       <= dst_nxt;
      src       <= src_nxt;
      cnt       <= cnt_nxt;
      pattern   <= pattern_nxt;
      hold_data <= hold_nxt;
      op        <= op_nxt;
    end
  end

endmodule

// File: tb/tb_core_rrv_vga_fill_ctrl.sv
// Bench for core_rrv_vga_fill_ctrl: port-A memory, step-queue reference model,
// directed scenarios with literal expectations and randomized commands with core traffic.
module tb_core_rrv_vga_fill_ctrl;

  localparam int MEM_WORDS = 9600;
  localparam int AW        = 14;

  logic          Clk_50 = 1'b0;
  logic          Reset  = 1'b1;
  logic          CoreWrEnQ503 = 1'b0;
  logic          CoreRdEnQ503 = 1'b0;
  logic [31:0]   CoreAddrQ503H = '0;
  logic [31:0]   CoreDataQ503H = '0;
  logic [3:0]    CoreByteEnQ503H = '0;
  logic [31:0]   CoreRspDataQ504H;
  logic          CmdValid = 1'b0;
  logic          CmdReady;
  logic          CmdOp = 1'b0;
  logic [AW-1:0] CmdDstWord = '0;
  logic [AW-1:0] CmdSrcWord = '0;
  logic [AW-1:0] CmdLenWords = '0;
  logic [31:0]   CmdPattern = '0;
  logic [AW-1:0] MemAddrWord;
  logic [31:0]   MemData;
  logic [3:0]    MemByteEn;
  logic          MemWrEn;
  logic          MemRdEn;
  logic [31:0]   MemRspData = '0;
  logic          Busy;
  logic          Done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk_50 = ~Clk_50;

  core_rrv_vga_fill_ctrl #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .Clk_50(Clk_50), .Reset(Reset),
    .CoreWrEnQ503(CoreWrEnQ503), .CoreRdEnQ503(CoreRdEnQ503),
    .CoreAddrQ503H(CoreAddrQ503H), .CoreDataQ503H(CoreDataQ503H),
    .CoreByteEnQ503H(CoreByteEnQ503H), .CoreRspDataQ504H(CoreRspDataQ504H),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
    .CmdDstWord(CmdDstWord), .CmdSrcWord(CmdSrcWord), .CmdLenWords(CmdLenWords),
    .CmdPattern(CmdPattern),
    .MemAddrWord(MemAddrWord), .MemData(MemData), .MemByteEn(MemByteEn),
    .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .MemRspData(MemRspData),
    .Busy(Busy), .Done(Done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Port-A frame memory with byte enables and 1-cycle read latency.
  logic [31:0] tb_mem [MEM_WORDS];
  int wr_cnt = 0;
  always @(posedge Clk_50) begin
    if (MemWrEn && int'(MemAddrWord) < MEM_WORDS) begin
      for (int b = 0; b < 4; b++)
        if (MemByteEn[b]) tb_mem[MemAddrWord][8*b +: 8] <= MemData[8*b +: 8];
    end
    if (MemWrEn) wr_cnt <= wr_cnt + 1;
    if (MemRdEn && int'(MemAddrWord) < MEM_WORDS) MemRspData <= tb_mem[MemAddrWord];
  end

  // Reference model: a command becomes a queue of port steps; a port step retires
  // only in a cycle the core leaves free, the capture step always retires.
  typedef enum {K_RD, K_CAP, K_WR} kind_t;
  typedef struct {
    kind_t       kind;
    int          addr;
    logic [31:0] data;
    bit          use_hold;
  } step_t;

  step_t       steps[$];
  step_t       h;
  bit          done_pend = 0;
  bit          rsp_pend  = 0;
  logic [31:0] rsp_exp   = '0;
  logic [31:0] m_hold    = '0;
  bit          core_e;
  bit          busy_e;

  always @(negedge Clk_50) begin
    if (Reset) begin
      steps.delete();
      done_pend = 0;
    end
    if (rsp_pend) check("core_rsp", CoreRspDataQ504H, rsp_exp);
    rsp_pend = 0;
    core_e = CoreWrEnQ503 | CoreRdEnQ503;
    busy_e = steps.size() != 0;
    check("busy", 32'(Busy), 32'(busy_e));
    check("done", 32'(Done), 32'(done_pend));
    check("cmd_ready", 32'(CmdReady), 32'(!busy_e && !done_pend));
    if (core_e) begin
      check("core_mem_addr", 32'(MemAddrWord), 32'(CoreAddrQ503H[AW+1:2]));
      check("core_mem_data", MemData, CoreDataQ503H);
      check("core_mem_be", 32'(MemByteEn), 32'(CoreByteEnQ503H));
      check("core_mem_wr", 32'(MemWrEn), 32'(CoreWrEnQ503));
      check("core_mem_rd", 32'(MemRdEn), 32'(CoreRdEnQ503));
    end else if (busy_e && steps[0].kind != K_CAP) begin
      h = steps[0];
      check("eng_mem_wr", 32'(MemWrEn), 32'(h.kind == K_WR));
      check("eng_mem_rd", 32'(MemRdEn), 32'(h.kind == K_RD));
      check("eng_mem_addr", 32'(MemAddrWord), 32'(h.addr));
      check("eng_mem_be", 32'(MemByteEn), 32'hF);
      if (h.kind == K_WR) check("eng_mem_data", MemData, h.use_hold ? m_hold : h.data);
    end else begin
      check("idle_mem_wr", 32'(MemWrEn), 32'd0);
      check("idle_mem_rd", 32'(MemRdEn), 32'd0);
    end
    if (CoreRdEnQ503) begin
      rsp_pend = 1;
      rsp_exp  = tb_mem[CoreAddrQ503H[AW+1:2]];
    end
    if (!Reset) begin
      if (done_pend) begin
        done_pend = 0;
      end else if (busy_e) begin
        if (steps[0].kind == K_CAP || !core_e) begin
          if (steps[0].kind == K_RD) m_hold = tb_mem[steps[0].addr];
          void'(steps.pop_front());
          if (steps.size() == 0) done_pend = 1;
        end
      end else if (CmdValid) begin
        for (int i = 0; i < int'(CmdLenWords); i++) begin
          if (CmdOp) begin
            steps.push_back('{K_RD,  (int'(CmdSrcWord) + i) % MEM_WORDS, 32'h0, 1'b0});
            steps.push_back('{K_CAP, 0, 32'h0, 1'b0});
            steps.push_back('{K_WR,  (int'(CmdDstWord) + i) % MEM_WORDS, 32'h0, 1'b1});
          end else begin
            steps.push_back('{K_WR, (int'(CmdDstWord) + i) % MEM_WORDS, CmdPattern, 1'b0});
          end
        end
        if (CmdLenWords == '0) done_pend = 1;
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic core_write(input int w, input logic [31:0] d);
    CoreWrEnQ503    = 1'b1;
    CoreAddrQ503H   = 32'(w) << 2;
    CoreDataQ503H   = d;
    CoreByteEnQ503H = 4'hF;
    @(posedge Clk_50); #1;
    CoreWrEnQ503    = 1'b0;
  endtask

  task automatic core_read(input int w, output logic [31:0] d);
    CoreRdEnQ503  = 1'b1;
    CoreAddrQ503H = 32'(w) << 2;
    @(posedge Clk_50); #1;
    CoreRdEnQ503  = 1'b0;
    @(negedge Clk_50);
    d = CoreRspDataQ504H;
    @(posedge Clk_50); #1;
  endtask

  // Cycle 1 is the first cycle after the accepting edge.
  task automatic run_cmd(input bit op, input int dst, input int src, input int len,
                         input logic [31:0] pat, input int wr_lo, input int wr_hi,
                         input int rd_at, input int core_word, input bit rnd,
                         output int done_cyc, output int busy_cyc);
    bit ok;
    int r;
    done_cyc    = -1;
    busy_cyc    = 0;
    CmdOp       = op;
    CmdDstWord  = AW'(dst);
    CmdSrcWord  = AW'(src);
    CmdLenWords = AW'(len);
    CmdPattern  = pat;
    CmdValid    = 1'b1;
    ok = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge Clk_50);
      if (CmdReady) begin
        ok = 1;
        break;
      end
      @(posedge Clk_50); #1;
    end
    @(posedge Clk_50); #1;
    CmdValid = 1'b0;
    if (!ok) begin
      timeout_fail("cmd_accept");
      return;
    end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (rnd) begin
        r = $urandom_range(0, 3);
        CoreWrEnQ503    = (r == 0);
        CoreRdEnQ503    = (r == 1);
        CoreAddrQ503H   = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, MEM_WORDS - 1)) << 2);
        CoreDataQ503H   = $urandom;
        CoreByteEnQ503H = 4'($urandom_range(0, 15));
      end else begin
        CoreWrEnQ503    = (cyc >= wr_lo) && (cyc <= wr_hi);
        CoreRdEnQ503    = (cyc == rd_at);
        CoreAddrQ503H   = 32'(core_word) << 2;
        CoreDataQ503H   = 32'hCAFE_0000 | 32'(cyc);
        CoreByteEnQ503H = 4'hF;
      end
      @(negedge Clk_50);
      if (Busy) busy_cyc++;
      if (Done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge Clk_50); #1;
    end
    if (done_cyc < 0) timeout_fail("cmd_done");
    @(posedge Clk_50); #1;
    CoreWrEnQ503 = 1'b0;
    CoreRdEnQ503 = 1'b0;
  endtask

  int          dc, bc, w0;
  logic [31:0] rd;

  initial begin
    repeat (2) @(posedge Clk_50);
    #1 Reset = 1'b0;
    @(negedge Clk_50);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_ready", 32'(CmdReady), 32'd1);
    check("rst_mem_wr", 32'(MemWrEn), 32'd0);
    check("rst_mem_rd", 32'(MemRdEn), 32'd0);
    @(posedge Clk_50); #1;

    // Uncontended fill.
    run_cmd(1'b0, 100, 0, 4, 32'hA5A5_A5A5, 0, -1, -1, 0, 1'b0, dc, bc);
    check("fill_done_cyc", 32'(dc), 32'd5);
    check("fill_busy_cyc", 32'(bc), 32'd4);
    for (int i = 0; i < 4; i++) check("fill_word", tb_mem[100 + i], 32'hA5A5_A5A5);

    // Core writes to word 16 on cycles 2-3 stall the engine.
    run_cmd(1'b0, 100, 0, 3, 32'h5A5A_0001, 2, 3, -1, 16, 1'b0, dc, bc);
    check("prio_done_cyc", 32'(dc), 32'd6);
    check("prio_core_word", tb_mem[16], 32'hCAFE_0003);
    check("prio_last_word", tb_mem[102], 32'h5A5A_0001);

    // Copy two words.
    core_write(200, 32'h1234_5678);
    core_write(201, 32'h9ABC_DEF0);
    run_cmd(1'b1, 10, 200, 2, 32'h0, 0, -1, -1, 0, 1'b0, dc, bc);
    check("copy_done_cyc", 32'(dc), 32'd7);
    core_read(10, rd);
    check("copy_word10", rd, 32'h1234_5678);
    core_read(11, rd);
    check("copy_word11", rd, 32'h9ABC_DEF0);

    // Address wrap and zero length.
    run_cmd(1'b0, 9598, 0, 3, 32'h0F0F_1234, 0, -1, -1, 0, 1'b0, dc, bc);
    check("wrap_done_cyc", 32'(dc), 32'd4);
    check("wrap_9598", tb_mem[9598], 32'h0F0F_1234);
    check("wrap_9599", tb_mem[9599], 32'h0F0F_1234);
    check("wrap_0", tb_mem[0], 32'h0F0F_1234);
    w0 = wr_cnt;
    run_cmd(1'b0, 50, 0, 0, 32'hFFFF_FFFF, 0, -1, -1, 0, 1'b0, dc, bc);
    check("len0_done_cyc", 32'(dc), 32'd1);
    check("len0_no_write", 32'(wr_cnt), 32'(w0));

    // Core load while the engine is capturing.
    core_write(500, 32'hDEAD_BEEF);
    run_cmd(1'b1, 600, 500, 1, 32'h0, 0, -1, 2, 16, 1'b0, dc, bc);
    check("cap_done_cyc", 32'(dc), 32'd4);
    check("cap_copy_word", tb_mem[600], 32'hDEAD_BEEF);

    // Reset during the third word of an 8-word fill.
    CmdOp = 1'b0; CmdDstWord = AW'(300); CmdLenWords = AW'(8);
    CmdPattern = 32'h7777_0008; CmdValid = 1'b1;
    @(posedge Clk_50); #1;
    CmdValid = 1'b0;
    @(posedge Clk_50); #1;
    @(posedge Clk_50); #1;
    Reset = 1'b1;
    #2;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_ready", 32'(CmdReady), 32'd1);
    @(posedge Clk_50); #1;
    @(posedge Clk_50); #1;
    Reset = 1'b0;
    w0 = wr_cnt;
    repeat (3) @(posedge Clk_50);
    #1;
    check("abort_no_write", 32'(wr_cnt), 32'(w0));
    run_cmd(1'b0, 700, 0, 2, 32'h3C3C_3C3C, 0, -1, -1, 0, 1'b0, dc, bc);
    check("post_abort_done_cyc", 32'(dc), 32'd3);

    // Randomized commands with random core traffic.
    for (int n = 0; n < 40; n++) begin
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, MEM_WORDS - 1),
              $urandom_range(0, MEM_WORDS - 1), $urandom_range(0, 12), $urandom,
              0, -1, -1, 0, 1'b1, dc, bc);
      repeat ($urandom_range(0, 2)) @(posedge Clk_50);
      #1;
    end

    repeat (2) @(posedge Clk_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
